alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, handshaked successor to the 8-bit combinational ALU.
//  - Adds registered outputs, valid/ready flow control and a zero flag.
//  - Adds iterative shift (1 bit/cycle) and iterative shift-add multiply.
//  - Sits between the register-file read stage and writeback; datapath width is set by W.
// PARAMETERS
//  W        8   datapath width in bits (>=4)
//  CMD_W    4   opcode width; low 3 bits keep the legacy codes
// PORTS
//  clk       in   1      clock, all state on rising edge
//  reset     in   1      asynchronous, active-high; clears all state
//  in_valid  in   1      request present
//  in_ready  out  1      block can accept (high only in IDLE)
//  alu_cmd   in   CMD_W  opcode, sampled at accept
//  inA       in   W      operand A (acc reg), sampled at accept
//  inB       in   W      operand B (reg/immediate, shift amount), sampled at accept
//  out_valid out  1      rslt/flag/zero valid
//  out_ready in   1      consumer takes result
//  rslt      out  W      result
//  flag      out  1      carry/borrow/compare/shift-out/overflow flag
//  zero      out  1      rslt == 0
// BEHAVIOUR
//  Reset: state IDLE; out_valid, rslt, flag, zero = 0; in_ready = 1 once reset deasserts.
//  Reset mid-operation aborts the op and discards the result.
//  Accept on in_valid && in_ready; operands and cmd are latched at that edge.
//  FSM:
//  - IDLE -> BUSY if op is iterative with N>0.
//  - IDLE -> DONE otherwise.
//  - BUSY: one step per cycle; -> DONE after N steps.
//  - DONE: out_valid=1; -> IDLE on out_ready.
//  Latency: out_valid rises N+1 cycles after the accept edge (N=0 for single-cycle ops).
//  Backpressure: while out_valid && !out_ready, rslt/flag/zero hold stable.
//  No new accept until DONE exits, so minimum issue interval is 2 cycles.
//  Opcodes (W-bit unsigned, results truncated to W):
//  - 0000 add:  rslt=A+B; flag=carry out (bit W).
//  - 0001 lsl:  iterative, N=min(B,W); flag=last bit shifted out (0 if N=0).
//  - 0010 movf: rslt=A; flag=0.
//  - 0011 xor:  rslt=A^B; flag=0.
//  - 0100 movi: rslt=B; flag=0.
//  - 0101 lsr:  iterative, N=min(B,W); flag=last bit shifted out (0 if N=0).
//  - 0110 sub:  rslt=A-B mod 2^W; flag=(B>A).
//  - 0111 cmp:  rslt=0; flag=(A==B).
//  - 1000 mul:  shift-add, N=W; rslt=low W bits of A*B; flag=|high W bits.
//  - 1001..1111: illegal; single-cycle, rslt=0, flag=0.
//  Shift-amount rule: B>=W clamps N to W.
//  - rslt=0.
//  - flag = A[0] for lsl, A[W-1] for lsr (the last bit out).
//  zero is computed from the final rslt; it is registered with rslt.
// STRUCTURE
//  alu_pkg:
//  - typedef enum alu_cmd_t (codes above).
//  - localparams for the legacy 3-bit subset.
//  - alu_state_t {IDLE, BUSY, DONE}.
//  Sub-module alu_comb: combinational single-cycle ops (add/xor/sub/cmp/mov/illegal) -> rslt, flag.
//  Top holds:
//  - FSM.
//  - Step counter ($clog2(W+1) bits).
//  - Shift/multiply working registers (2W-bit product accumulator).
//  - Output registers.
// TESTING (W=8)
//  - add FF+01, out_ready=1 -> out_valid 1 cycle after accept; rslt=00, flag=1, zero=1.
//  - lsl A=60 B=2 -> 2 BUSY cycles, out_valid at +3; rslt=80, flag=1.
//  - lsr A=81 B=9 (clamped to 8) -> out_valid at +9; rslt=00, flag=1, zero=1.
//  - mul 10*10 -> out_valid at +9; rslt=00, flag=1.
//  - mul 0F*03 -> rslt=2D, flag=0.
//  - sub 03-05 -> rslt=FE, flag=1.
//  - cmp 5A,5A -> rslt=00, flag=1.
//  - Backpressure: hold out_ready=0 for 4 cycles after sub result -> outputs stable, in_ready=0.
//    Then out_ready=1 -> IDLE, in_ready=1 next cycle.
//  - Assert reset 3 cycles into mul 10*10 -> out_valid=0, rslt=0, in_ready=1 after release.
//    A following add 01+01 returns 02.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and the
// legacy 3-bit opcode subset inherited from the combinational ALU.
package alu_seq_pkg;

    // Legacy 3-bit opcodes; the 4-bit codes keep these in their low bits.
    localparam logic [2:0] LEG_ADD  = 3'b000;
    localparam logic [2:0] LEG_LSL  = 3'b001;
    localparam logic [2:0] LEG_MOVF = 3'b010;
    localparam logic [2:0] LEG_XOR  = 3'b011;
    localparam logic [2:0] LEG_MOVI = 3'b100;
    localparam logic [2:0] LEG_LSR  = 3'b101;
    localparam logic [2:0] LEG_SUB  = 3'b110;
    localparam logic [2:0] LEG_CMP  = 3'b111;

    typedef enum logic [3:0] {
        CMD_ADD  = {1'b0, LEG_ADD},
        CMD_LSL  = {1'b0, LEG_LSL},
        CMD_MOVF = {1'b0, LEG_MOVF},
        CMD_XOR  = {1'b0, LEG_XOR},
        CMD_MOVI = {1'b0, LEG_MOVI},
        CMD_LSR  = {1'b0, LEG_LSR},
        CMD_SUB  = {1'b0, LEG_SUB},
        CMD_CMP  = {1'b0, LEG_CMP},
        CMD_MUL  = 4'b1000,
        CMD_ILL  = 4'b1111      // any code above MUL is folded onto this
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the register-read stage (master) and
// the sequential ALU (slave).
//
// Handshake: a request transfers on a rising clk edge where in_valid and
// in_ready are both high; a response transfers on an edge where out_valid
// and out_ready are both high. Once raised, out_valid stays high and
// rslt/flag/zero stay stable until the response transfers.
interface alu_seq_if #(
    parameter int W     = 8,
    parameter int CMD_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [CMD_W-1:0] alu_cmd;
    logic [W-1:0]     inA;
    logic [W-1:0]     inB;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     rslt;
    logic             flag;
    logic             zero;

    modport master (
        output in_valid, alu_cmd, inA, inB, out_ready,
        input  in_ready, out_valid, rslt, flag, zero
    );

    modport slave (
        input  in_valid, alu_cmd, inA, inB, out_ready,
        output in_ready, out_valid, rslt, flag, zero
    );
endinterface

// File: rtl/alu_seq_comb.sv
// Single-cycle ALU operations. For lsl/lsr this yields the zero-shift
// result (A, flag 0); multi-step shifts and mul are handled by the top.
module alu_seq_comb
    import alu_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  alu_cmd_t     cmd_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] rslt_o,
    output logic         flag_o
);
    logic [W:0] sum;

    // Decode the opcode into a result and its flag.
    always_comb begin
        sum    = {1'b0, a_i} + {1'b0, b_i};
        rslt_o = '0;
        flag_o = 1'b0;
        case (cmd_i)
            CMD_ADD:  begin rslt_o = sum[W-1:0]; flag_o = sum[W];    end
            CMD_LSL,
            CMD_LSR,
            CMD_MOVF: rslt_o = a_i;
            CMD_XOR:  rslt_o = a_i ^ b_i;
            CMD_MOVI: rslt_o = b_i;
            CMD_SUB:  begin rslt_o = a_i - b_i;  flag_o = (b_i > a_i); end
            CMD_CMP:  flag_o = (a_i == b_i);
            default:  ;
        endcase
    end
endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered outputs. Single-cycle ops finish on the
// accept edge; shifts step one bit per cycle and mul runs W shift-add steps.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int W     = 8,
    parameter int CMD_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    alu_seq_if.slave   bus,
    output alu_state_t state_o
);
    localparam int             CW    = $clog2(W + 1);
    localparam logic [CW-1:0]  N_MAX = CW'(W);
    localparam logic [W-1:0]   W_B   = W'(W);

    alu_state_t     state_q, state_d;
    alu_cmd_t       op_q, op_d;
    logic [CW-1:0]  cnt_q, cnt_d, n_q, n_d;
    logic [2*W-1:0] a_q, a_d, acc_q, acc_d;
    logic [W-1:0]   b_q, b_d;
    logic           sflag_q, sflag_d;
    logic [W-1:0]   rslt_q, rslt_d;
    logic           flag_q, flag_d, zero_q, zero_d;

    alu_cmd_t       dec_cmd;
    logic [W-1:0]   comb_rslt;
    logic           comb_flag;
    logic           accept;
    logic           iter;
    logic [CW-1:0]  n_req;
    logic [2*W-1:0] step_a, step_acc;
    logic [W-1:0]   step_b, fin_rslt;
    logic           step_flag, fin_flag;

    assign dec_cmd = (bus.alu_cmd <= CMD_W'(CMD_MUL)) ? alu_cmd_t'(bus.alu_cmd[3:0]) : CMD_ILL;
    assign accept  = bus.in_valid && bus.in_ready;

    alu_seq_comb #(.W(W)) u_comb (
        .cmd_i  (dec_cmd),
        .a_i    (bus.inA),
        .b_i    (bus.inB),
        .rslt_o (comb_rslt),
        .flag_o (comb_flag)
    );

    // Step count for the requested op; shift amounts of W or more clamp to W.
    always_comb begin
        n_req = '0;
        iter  = 1'b0;
        if (dec_cmd == CMD_MUL) begin
            n_req = N_MAX;
            iter  = 1'b1;
        end else if (dec_cmd == CMD_LSL || dec_cmd == CMD_LSR) begin
            n_req = (bus.inB >= W_B) ? N_MAX : bus.inB[CW-1:0];
            iter  = (n_req != '0);
        end
    end

    // One iteration of the working registers, plus the result it would give.
    always_comb begin
        step_a    = a_q;
        step_b    = b_q;
        step_acc  = acc_q;
        step_flag = sflag_q;
        case (op_q)
            CMD_LSL: begin
                step_a    = {{W{1'b0}}, a_q[W-2:0], 1'b0};
                step_flag = a_q[W-1];
            end
            CMD_LSR: begin
                step_a    = {{W{1'b0}}, 1'b0, a_q[W-1:1]};
                step_flag = a_q[0];
            end
            CMD_MUL: begin
                step_acc = acc_q + (b_q[0] ? a_q : '0);
                step_a   = a_q << 1;
                step_b   = b_q >> 1;
            end
            default: ;
        endcase
        if (op_q == CMD_MUL) begin
            fin_rslt = step_acc[W-1:0];
            fin_flag = |step_acc[2*W-1:W];
        end else begin
            fin_rslt = step_a[W-1:0];
            fin_flag = step_flag;
        end
    end

    // FSM next-state and working/output register updates.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sflag_d = sflag_q;
        rslt_d  = rslt_q;
        flag_d  = flag_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = dec_cmd;
                    cnt_d   = '0;
                    n_d     = n_req;
                    a_d     = {{W{1'b0}}, bus.inA};
                    b_d     = bus.inB;
                    acc_d   = '0;
                    sflag_d = 1'b0;
                    if (iter) begin
                        state_d = BUSY;
                    end else begin
                        state_d = DONE;
                        rslt_d  = comb_rslt;
                        flag_d  = comb_flag;
                        zero_d  = (comb_rslt == '0);
                    end
                end
            end
            BUSY: begin
                cnt_d   = cnt_q + CW'(1);
                a_d     = step_a;
                b_d     = step_b;
                acc_d   = step_acc;
                sflag_d = step_flag;
                if (cnt_d == n_q) begin
                    state_d = DONE;
                    rslt_d  = fin_rslt;
                    flag_d  = fin_flag;
                    zero_d  = (fin_rslt == '0);
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, working and output registers; reset aborts any op in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= CMD_ADD;
            cnt_q   <= '0;
            n_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sflag_q <= 1'b0;
            rslt_q  <= '0;
            flag_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sflag_q <= sflag_d;
            rslt_q  <= rslt_d;
            flag_q  <= flag_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !reset;
    assign bus.out_valid = (state_q == DONE);
    assign bus.rslt      = rslt_q;
    assign bus.flag      = flag_q;
    assign bus.zero      = zero_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at W=8: a driver issues requests and pushes
// the hand-computed response; a monitor pops and compares on each transfer.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W     = 8;
    localparam int CMD_W = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    alu_state_t state_dbg;

    int checks = 0;
    int errors = 0;

    logic [W+1:0] exp_q[$];
    logic [W+1:0] mon_got;
    logic [W+1:0] mon_want;
    logic         saw_valid;

    alu_seq_if #(.W(W), .CMD_W(CMD_W)) bus ();

    alu_seq #(.W(W), .CMD_W(CMD_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .state_o (state_dbg)
    );

    // Clock and global watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Called just after a rising edge; waits (bounded) for in_ready.
    task automatic wait_ready(input string name);
        int g;
        g = 0;
        while (!bus.in_ready && g < 40) begin
            @(posedge clk); #1;
            g++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s in_ready timeout: got 0 expected 1", name);
        end
    endtask

    // Issue one request, queue its expected response and check latency
    // (edges from accept until out_valid is visible).
    task automatic send(input string name, input logic [3:0] cmd, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] r, input logic f,
                        input int lat);
        int n;
        wait_ready(name);
        bus.in_valid = 1'b1;
        bus.alu_cmd  = cmd;
        bus.inA      = a;
        bus.inB      = b;
        exp_q.push_back({r, f, (r == 8'h00)});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " latency"}, 16'(n), 16'(lat));
    endtask

    // Scoreboard monitor: compares every response that transfers.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            mon_got = {bus.rslt, bus.flag, bus.zero};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL result unexpected: got %h expected none", mon_got);
            end else begin
                mon_want = exp_q.pop_front();
                check("result {rslt,flag,zero}", 16'(mon_got), 16'(mon_want));
            end
        end
    end

    // Stimulus.
    initial begin
        bus.in_valid  = 1'b0;
        bus.alu_cmd   = '0;
        bus.inA       = '0;
        bus.inB       = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("reset in_ready",  16'(bus.in_ready),  16'd1);
        check("reset out_valid", 16'(bus.out_valid), 16'd0);
        check("reset rslt",      16'(bus.rslt),      16'd0);
        check("reset flag",      16'(bus.flag),      16'd0);
        check("reset zero",      16'(bus.zero),      16'd0);
        check("reset state",     16'(state_dbg),     16'(IDLE));
        @(posedge clk); #1;

        //    name           cmd    A      B      rslt   flag  lat
        send("add FF+01",   4'h0, 8'hFF, 8'h01, 8'h00, 1'b1, 1);
        send("add 80+7F",   4'h0, 8'h80, 8'h7F, 8'hFF, 1'b0, 1);
        send("lsl 60<<2",   4'h1, 8'h60, 8'h02, 8'h80, 1'b1, 3);
        send("lsl 81<<0",   4'h1, 8'h81, 8'h00, 8'h81, 1'b0, 1);
        send("lsl 81<<8",   4'h1, 8'h81, 8'h08, 8'h00, 1'b1, 9);
        send("lsr 81>>9",   4'h5, 8'h81, 8'h09, 8'h00, 1'b1, 9);
        send("lsr 0C>>3",   4'h5, 8'h0C, 8'h03, 8'h01, 1'b1, 4);
        send("mul 10*10",   4'h8, 8'h10, 8'h10, 8'h00, 1'b1, 9);
        send("mul 0F*03",   4'h8, 8'h0F, 8'h03, 8'h2D, 1'b0, 9);
        send("mul FF*FF",   4'h8, 8'hFF, 8'hFF, 8'h01, 1'b1, 9);
        send("xor A5^FF",   4'h3, 8'hA5, 8'hFF, 8'h5A, 1'b0, 1);
        send("movf 3C",     4'h2, 8'h3C, 8'h99, 8'h3C, 1'b0, 1);
        send("movi 99",     4'h4, 8'h3C, 8'h99, 8'h99, 1'b0, 1);
        send("sub 05-03",   4'h6, 8'h05, 8'h03, 8'h02, 1'b0, 1);
        send("cmp 5A,5B",   4'h7, 8'h5A, 8'h5B, 8'h00, 1'b0, 1);
        send("illegal 9",   4'h9, 8'h12, 8'h34, 8'h00, 1'b0, 1);
        send("illegal F",   4'hF, 8'hFF, 8'hFF, 8'h00, 1'b0, 1);

        // Backpressure: result must hold while the consumer stalls.
        wait_ready("sub 03-05");
        bus.out_ready = 1'b0;
        send("sub 03-05",   4'h6, 8'h03, 8'h05, 8'hFE, 1'b1, 1);
        for (int i = 0; i < 4; i++) begin
            check("stall out_valid", 16'(bus.out_valid), 16'd1);
            check("stall rslt",      16'(bus.rslt),      16'hFE);
            check("stall flag",      16'(bus.flag),      16'd1);
            check("stall zero",      16'(bus.zero),      16'd0);
            check("stall in_ready",  16'(bus.in_ready),  16'd0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("release in_ready",  16'(bus.in_ready),  16'd1);
        check("release out_valid", 16'(bus.out_valid), 16'd0);

        send("cmp 5A,5A",   4'h7, 8'h5A, 8'h5A, 8'h00, 1'b1, 1);

        // Reset three cycles into a multiply discards it.
        wait_ready("mul abort");
        bus.in_valid = 1'b1;
        bus.alu_cmd  = 4'h8;
        bus.inA      = 8'h10;
        bus.inB      = 8'h10;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("abort state busy", 16'(state_dbg), 16'(BUSY));
        reset = 1'b1;
        #1;
        check("abort out_valid", 16'(bus.out_valid), 16'd0);
        check("abort rslt",      16'(bus.rslt),      16'd0);
        check("abort state",     16'(state_dbg),     16'(IDLE));
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        check("abort in_ready", 16'(bus.in_ready), 16'd1);
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            saw_valid = saw_valid | bus.out_valid;
        end
        check("abort no result", 16'(saw_valid), 16'd0);

        send("add 01+01",   4'h0, 8'h01, 8'h01, 8'h02, 1'b0, 1);

        repeat (3) begin
            @(posedge clk); #1;
        end
        check("queue drained", 16'(exp_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
